// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for the sram_1rw1r_param macro model.
//   state_e     : init sequencer states (INIT fills memory, READY serves ports)
//   lane_merge  : byte-lane merge used by port 0 writes and by read forwarding
package sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Widest word lane_merge can handle. Callers zero-extend their operands
  // and keep only the low DATA_WIDTH bits of the result.
  localparam int unsigned MERGE_MAX_W = 512;

  // Bit i takes new_w when the lane that owns it (i / lane_w) is enabled,
  // otherwise it keeps old_w.
  function automatic logic [MERGE_MAX_W-1:0] lane_merge(
    input logic [MERGE_MAX_W-1:0] old_w,
    input logic [MERGE_MAX_W-1:0] new_w,
    input logic [MERGE_MAX_W-1:0] mask,
    input int unsigned            lane_w
  );
    logic [MERGE_MAX_W-1:0] r;
    r = old_w;
    if (lane_w != 0) begin
      for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
        if (mask[9'(i / lane_w)]) r[9'(i)] = new_w[9'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_1rw1r_init_seq.sv
// sram_1rw1r_init_seq: post-reset initialisation sequencer.
// Walks every address once (one per cycle) while in INIT, then parks in READY
// until the next reset.
//   clk_i        : clock, posedge
//   rst_ni       : asynchronous active-low reset
//   ready_o      : high once every address has been written
//   init_we_o    : write strobe for the init value
//   init_addr_o  : address being initialised this cycle
module sram_1rw1r_init_seq
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  ready_o,
  output logic                  init_we_o,
  output logic [ADDR_WIDTH-1:0] init_addr_o
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      INIT: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == '1) state_d = READY;
      end
      READY: ;
      default: state_d = INIT;
    endcase
  end

  assign ready_o     = (state_q == READY);
  assign init_we_o   = (state_q == INIT);
  assign init_addr_o = addr_q;

endmodule

// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: parametrised single-clock 1RW1R SRAM model.
// Port 0 reads or writes (byte-lane masked), port 1 reads only. Read data is
// registered (1-cycle latency) with a one-cycle valid strobe; outputs hold
// between reads. Memory is filled with INIT_VALUE after reset and all port
// traffic is ignored until ready is high.
//   clk0, rstb                       : clock (posedge), async active-low reset
//   ready                            : initialisation complete
//   csb0, web0, wmask0, addr0, din0  : port 0 request (active-low select/write)
//   dout0, dvalid0                   : port 0 read data and valid
//   csb1, addr1                      : port 1 request
//   dout1, dvalid1                   : port 1 read data and valid
//   collision                        : port 0 write and port 1 read hit the
//                                      same address (aligned with dvalid1)
// Build option: define SRAM_1RW1R_FWD_EN to return the merged (post-write)
// word on dout1 during a collision; otherwise the pre-write word is returned.
// DATA_WIDTH must be below sram_pkg::MERGE_MAX_W and a multiple of WMASK_WIDTH.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 64,
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           WMASK_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                   clk0,
  input  logic                   rstb,
  output logic                   ready,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   dvalid0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dvalid1,
  output logic                   collision
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LANE      = DATA_WIDTH / WMASK_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  sram_1rw1r_init_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_init_seq (
    .clk_i       (clk0),
    .rst_ni      (rstb),
    .ready_o     (ready),
    .init_we_o   (init_we),
    .init_addr_o (init_addr)
  );

  logic p0_wr, p0_rd, p1_rd, coll_d;
  assign p0_wr  = ready & ~csb0 & ~web0;
  assign p0_rd  = ready & ~csb0 &  web0;
  assign p1_rd  = ready & ~csb1;
  assign coll_d = p0_wr & p1_rd & (addr0 == addr1) & (|wmask0);

  logic [MERGE_MAX_W-1:0] wr_full;
  logic [DATA_WIDTH-1:0]  wr_word;
  assign wr_full = lane_merge(MERGE_MAX_W'(mem_q[addr0]), MERGE_MAX_W'(din0),
                              MERGE_MAX_W'(wmask0), LANE);
  assign wr_word = wr_full[DATA_WIDTH-1:0];

`ifdef SRAM_1RW1R_FWD_EN
  logic [MERGE_MAX_W-1:0] fwd_full;
  logic [DATA_WIDTH-1:0]  fwd_word;
  assign fwd_full = lane_merge(MERGE_MAX_W'(mem_q[addr1]), MERGE_MAX_W'(din0),
                               MERGE_MAX_W'(wmask0), LANE);
  assign fwd_word = fwd_full[DATA_WIDTH-1:0];
  logic unused_hi;
  assign unused_hi = ^{wr_full[MERGE_MAX_W-1:DATA_WIDTH],
                       fwd_full[MERGE_MAX_W-1:DATA_WIDTH]};
`else
  logic unused_hi;
  assign unused_hi = ^wr_full[MERGE_MAX_W-1:DATA_WIDTH];
`endif

  // Memory contents are deliberately not reset; the init sequencer owns the
  // write port until ready, so port 0 can never collide with it.
  always_ff @(posedge clk0) begin
    if (init_we) begin
      mem_q[init_addr] <= INIT_VALUE;
    end else if (p0_wr && (|wmask0)) begin
      mem_q[addr0] <= wr_word;
    end
  end

  logic [DATA_WIDTH-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
  logic                  dvalid0_q, dvalid1_q, coll_q;

  always_comb begin
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    if (p0_rd) dout0_d = mem_q[addr0];
    if (p1_rd) dout1_d = mem_q[addr1];
`ifdef SRAM_1RW1R_FWD_EN
    if (coll_d) dout1_d = fwd_word;
`endif
  end

  always_ff @(posedge clk0 or negedge rstb) begin
    if (!rstb) begin
      dout0_q   <= '0;
      dout1_q   <= '0;
      dvalid0_q <= 1'b0;
      dvalid1_q <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      dout0_q   <= dout0_d;
      dout1_q   <= dout1_d;
      dvalid0_q <= p0_rd;
      dvalid1_q <= p1_rd;
      coll_q    <= coll_d;
    end
  end

  assign dout0     = dout0_q;
  assign dout1     = dout1_q;
  assign dvalid0   = dvalid0_q;
  assign dvalid1   = dvalid1_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Self-checking bench for sram_1rw1r_param (default 64x256 instance plus a
// 32-bit x 16-word instance for the small-geometry case).
module tb_sram_1rw1r_param;

  logic        clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic        rstb;
  logic        csb0, web0, csb1;
  logic [7:0]  wmask0, addr0, addr1;
  logic [63:0] din0, dout0, dout1;
  logic        ready, dvalid0, dvalid1, collision;

  logic        s_csb0, s_web0, s_csb1;
  logic [3:0]  s_wmask0, s_addr0, s_addr1;
  logic [31:0] s_din0, s_dout0, s_dout1;
  logic        s_ready, s_dvalid0, s_dvalid1, s_collision;

  sram_1rw1r_param u_dut (
    .clk0(clk0), .rstb(rstb), .ready(ready),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0), .dvalid0(dvalid0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1), .dvalid1(dvalid1),
    .collision(collision)
  );

  sram_1rw1r_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .WMASK_WIDTH(4)
  ) u_small (
    .clk0(clk0), .rstb(rstb), .ready(s_ready),
    .csb0(s_csb0), .web0(s_web0), .wmask0(s_wmask0), .addr0(s_addr0), .din0(s_din0),
    .dout0(s_dout0), .dvalid0(s_dvalid0),
    .csb1(s_csb1), .addr1(s_addr1), .dout1(s_dout1), .dvalid1(s_dvalid1),
    .collision(s_collision)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    logic [63:0] data;
    logic        coll;
    int unsigned due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [63:0] ref_mem [256];
  bit          mdl_ready = 1'b0;
  int unsigned cyc = 0;

  always @(posedge clk0) cyc <= cyc + 1;

  function automatic logic [63:0] mrg(input logic [63:0] old_w, input logic [63:0] new_w,
                                      input logic [7:0] m);
    logic [63:0] r;
    r = old_w;
    for (int l = 0; l < 8; l++) if (m[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    return r;
  endfunction

  // One cycle of stimulus; expectations are queued before the model memory
  // sees this cycle's write, so same-cycle reads get the old word.
  task automatic drive(input bit e0, input bit w0, input logic [7:0] m, input logic [7:0] a0,
                       input logic [63:0] d, input bit e1, input logic [7:0] a1);
    exp_t ent;
    bit   coll;
    csb0 = !e0; web0 = !w0; wmask0 = m; addr0 = a0; din0 = d;
    csb1 = !e1; addr1 = a1;
    if (mdl_ready) begin
      coll = e0 && w0 && e1 && (a0 == a1) && (m != 8'h00);
      if (e1) begin
        ent.data = ref_mem[a1];
`ifdef SRAM_1RW1R_FWD_EN
        if (coll) ent.data = mrg(ref_mem[a1], d, m);
`endif
        ent.coll = coll;
        ent.due  = cyc + 1;
        q1.push_back(ent);
      end
      if (e0 && !w0) begin
        ent.data = ref_mem[a0];
        ent.coll = 1'b0;
        ent.due  = cyc + 1;
        q0.push_back(ent);
      end
      if (e0 && w0) ref_mem[a0] = mrg(ref_mem[a0], d, m);
    end
    @(posedge clk0); #1;
    csb0 = 1'b1; csb1 = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk0); #1; end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 400) begin @(posedge clk0); #1; n++; end
    check(tag, 64'(n), 64'd256);
    mdl_ready = ready;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"},   64'(ready),     64'd0);
    check({pfx, "_dout0"},   dout0,          64'd0);
    check({pfx, "_dout1"},   dout1,          64'd0);
    check({pfx, "_dvalid0"}, 64'(dvalid0),   64'd0);
    check({pfx, "_dvalid1"}, 64'(dvalid1),   64'd0);
    check({pfx, "_coll"},    64'(collision), 64'd0);
  endtask

  always @(negedge clk0) begin
    exp_t e;
    if (dvalid0) begin
      if (q0.size() == 0) check("dvalid0_spurious", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        check("dout0", dout0, e.data);
        check("lat0", 64'(cyc), 64'(e.due));
      end
    end else if (q0.size() != 0 && q0[0].due <= cyc) begin
      check("dvalid0_missing", 64'd0, 64'd1);
      void'(q0.pop_front());
    end
    if (dvalid1) begin
      if (q1.size() == 0) check("dvalid1_spurious", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        check("dout1", dout1, e.data);
        check("collision", 64'(collision), 64'(e.coll));
        check("lat1", 64'(cyc), 64'(e.due));
      end
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      check("dvalid1_missing", 64'd0, 64'd1);
      void'(q1.pop_front());
    end
    if (collision && !dvalid1) check("collision_spurious", 64'd1, 64'd0);
  end

  initial begin
    rstb = 1'b0;
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
    s_csb0 = 1'b1; s_web0 = 1'b1; s_wmask0 = '0; s_addr0 = '0; s_din0 = '0;
    s_csb1 = 1'b1; s_addr1 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    tick(3);
    check_reset_outputs("rst");
    rstb = 1'b1;
    wait_ready("init_cycles");
    check("small_ready", 64'(s_ready), 64'd1);

    // first and last address hold INIT_VALUE, both ports
    drive(1, 0, 8'h00, 8'h00, '0, 1, 8'hFF);
    drive(1, 0, 8'h00, 8'hFF, '0, 1, 8'h00);
    // low-lane masked write then read back on the next cycle
    drive(1, 1, 8'h0F, 8'h10, 64'h1122334455667788, 0, 8'h00);
    drive(1, 0, 8'h00, 8'h10, '0, 0, 8'h00);
    // empty mask changes nothing
    drive(1, 1, 8'h00, 8'h10, '1, 0, 8'h00);
    drive(1, 0, 8'h00, 8'h10, '0, 1, 8'h10);
    // collisions: full mask, empty mask, other address, partial mask
    drive(1, 1, 8'hFF, 8'h20, '1, 1, 8'h20);
    drive(1, 0, 8'h00, 8'h20, '0, 1, 8'h20);
    drive(1, 1, 8'h00, 8'h20, '0, 1, 8'h20);
    drive(1, 1, 8'hFF, 8'h21, 64'hA5A5_5A5A_0F0F_F0F0, 1, 8'h20);
    drive(1, 1, 8'hF0, 8'h20, 64'h0123_4567_89AB_CDEF, 1, 8'h20);
    drive(1, 0, 8'h00, 8'h20, '0, 1, 8'h21);

    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
            8'h30 + 8'($urandom_range(0, 3)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 8'h30 + 8'($urandom_range(0, 3)));
    end

    // small geometry: top lane only
    s_csb0 = 1'b0; s_web0 = 1'b0; s_wmask0 = 4'h8; s_addr0 = 4'hF; s_din0 = 32'hAABBCCDD;
    tick(1);
    s_csb0 = 1'b1; s_csb1 = 1'b0; s_addr1 = 4'hF;
    tick(1);
    s_csb1 = 1'b1;
    check("small_dout1", 64'(s_dout1), 64'h0000_0000_AA00_0000);
    check("small_dvalid1", 64'(s_dvalid1), 64'd1);
    check("small_dvalid0", 64'(s_dvalid0), 64'd0);
    check("small_coll", 64'(s_collision), 64'd0);

    // leave non-zero data on both outputs before reset
    drive(1, 0, 8'h00, 8'h10, '0, 1, 8'h10);
    tick(2);

    rstb = 1'b0; mdl_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    #1;
    check_reset_outputs("rst_ready_state");
    tick(2);
    rstb = 1'b1;

    // requests during INIT: address 5 is already initialised by now
    tick(50);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 8'hFF, 8'h05, '1, 1, 8'h05);
      drive(1, 0, 8'h00, 8'h05, '0, 1, 8'h05);
    end
    tick(30);
    check("mid_init_ready", 64'(ready), 64'd0);
    rstb = 1'b0;
    #1;
    check_reset_outputs("rst_mid_init");
    tick(2);
    rstb = 1'b1;
    wait_ready("reinit_cycles");

    drive(1, 0, 8'h00, 8'h05, '0, 1, 8'h05);
    drive(1, 0, 8'h00, 8'h10, '0, 1, 8'h20);
    drive(1, 0, 8'h00, 8'hFF, '0, 1, 8'h64);
    tick(3);
    check("sb_drain0", 64'(q0.size()), 64'd0);
    check("sb_drain1", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
